user_io_spi_sync: RTL and testbench
===================================

USER_IO_SPI_SYNC -- requirements
Module: user_io_spi_sync

Interface
REQ-001 Parameters SHALL be:
- NUM_JOY, default 5, joystick channel count, 1..8.
- JOY_W, default 32, bits per joystick, multiple of 8, 8..32.
- STATUS_W, default 64, status width, multiple of 8, 8..64.
- FIFO_AW, default 6, serial FIFO depth 2^FIFO_AW.
- CORE_TYPE, default 8'hA4, identification byte.

REQ-002 Ports SHALL be, in this order:
- clk_sys  in  1  sole clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high.
- SPI_CLK  in  1  SPI clock, asynchronous.
- SPI_SS_IO  in  1  chip select, active-low, asynchronous.
- SPI_MOSI  in  1  SPI data in, asynchronous.
- SPI_MISO  out  1  SPI data out.
- spi_miso_oe  out  1  high while selected.
- joystick  out  NUM_JOY*JOY_W  channel n at [n*JOY_W +: JOY_W].
- status  out  STATUS_W  core status word.
- buttons  out  2  but_sw[1:0].
- switches  out  2  but_sw[3:2].
- scandoubler_disable  out  1  but_sw[4].
- serial_data  in  8  byte to host.
- serial_strobe  in  1  one-cycle push request.
- serial_full  out  1  FIFO full.
- serial_overflow  out  1  sticky drop flag.

Function
REQ-003 SPI_CLK, SPI_SS_IO and SPI_MOSI SHALL each pass a 2-flop synchroniser; SPI_CLK edges SHALL be detected from the synchronised value; the supported SPI_CLK rate is ≤ clk_sys/8 (SPI mode 0).

REQ-004 On each detected SCK rising edge while selected, MOSI SHALL be shifted MSB-first into the receive register and the bit counter SHALL increment.

REQ-005 On each detected SCK falling edge while selected, SPI_MISO SHALL present the next MSB-first bit of the transmit register.

REQ-006 On the 8th rising edge, rx_done SHALL pulse for one cycle and byte_cnt SHALL increment, saturating at 1023; byte 0 is the command byte.

REQ-007 Register writes SHALL be visible on outputs in the cycle after rx_done.

REQ-008 On the select edge (SS high→low), the transmit register SHALL load CORE_TYPE.

REQ-009 At each rx_done, the transmit register SHALL load the response for the following byte.

REQ-010 Command 0x01: data byte 1 SHALL be written to but_sw[7:0].

REQ-011 Commands 0x60+n, n<NUM_JOY: data bytes 1..JOY_W/8 SHALL be written LSB-first to joystick channel n; excess bytes SHALL be ignored.

REQ-012 Command 0x15 SHALL write status[7:0].

REQ-013 Command 0x1E SHALL write bytes 1..STATUS_W/8 LSB-first into status; excess bytes SHALL be ignored.

REQ-014 Command 0x1B responses SHALL alternate as follows:
- Odd byte index: status byte {7'b1000000, avail}, sampled at load time.
- Even byte index ≥2: FIFO head if avail, else 0x00.
- Pop occurs in the same cycle as the head load, and only if avail.

REQ-015 Command 0x1F SHALL clear serial_overflow at rx_done of byte 0.

REQ-016 Unknown commands SHALL respond 0x00 and write nothing; 0x60+n with n≥NUM_JOY SHALL count as unknown.

REQ-017 FIFO push rules:
- serial_strobe with FIFO not full pushes serial_data.
- serial_strobe with FIFO full drops the byte and sets serial_overflow.
- Push and pop in the same cycle are both accepted, including when full.
- Pointers wrap modulo 2^FIFO_AW.

REQ-018 serial_full SHALL equal count == 2^FIFO_AW.

REQ-019 On SS deassert (synchronised high), bit and byte counters SHALL clear, a partial byte SHALL be discarded with no write, and spi_miso_oe SHALL fall within 3 cycles.

Reset
REQ-020 When reset is high, the following SHALL hold:
- joystick, status, but_sw, FIFO pointers, serial_overflow, counters = 0.
- SPI_MISO = 0, spi_miso_oe = 0.
- Transmit register = CORE_TYPE.
- Reset overrides any simultaneous event.

REQ-021 Reset asserted mid-transfer SHALL abort the transfer; the next byte is treated as byte 0 only after a fresh select edge.

Structure
REQ-022 Package user_io_pkg SHALL hold the command constants (CMD_BUT_SW, CMD_JOY_BASE, CMD_STATUS8, CMD_STATUS, CMD_SER_RD, CMD_SER_CLR) and the FIFO status prefix 7'b1000000.

REQ-023 The serial FIFO SHALL be a separate sub-module user_io_fifo (parameter AW, width 8), with push, pop, dout, empty, full and a synchronous reset.

Verification
REQ-024 Select, send 0x60 0x11 0x22 0x33 0x44 0x55 -> joystick[31:0]=0x44332211; fifth data byte ignored; first MISO byte = 0xA4.

REQ-025 Send 0x1E 0x01..0x08 -> status=0x0807060504030201; then 0x15 0xFF -> status[7:0]=0xFF, upper bits unchanged.

REQ-026 Push 0x41,0x42; read 0x1B plus 5 bytes -> MISO: 0x81,0x41,0x81,0x42,0x80; FIFO then empty.

REQ-027 Push 65 bytes with FIFO_AW=6 -> serial_full=1, serial_overflow=1, 64 bytes retained in order; command 0x1F clears overflow.

REQ-028 Deassert SS after 5 bits of 0x01 -> but_sw unchanged; the next transfer decodes its first byte as a command.

REQ-029 Assert reset during a 0x61 transfer -> all outputs zero; later bytes are ignored until a new select.

Source files
------------

// File: rtl/user_io_pkg.sv
// Shared command codes and response helpers for the user I/O SPI slave.
package user_io_pkg;

  localparam logic [7:0] CMD_BUT_SW   = 8'h01;
  localparam logic [7:0] CMD_JOY_BASE = 8'h60;
  localparam logic [7:0] CMD_STATUS8  = 8'h15;
  localparam logic [7:0] CMD_STATUS   = 8'h1E;
  localparam logic [7:0] CMD_SER_RD   = 8'h1B;
  localparam logic [7:0] CMD_SER_CLR  = 8'h1F;

  localparam logic [6:0] SER_STAT_PREFIX = 7'b1000000;

  function automatic logic [7:0] ser_status(input logic avail);
    return {SER_STAT_PREFIX, avail};
  endfunction

endpackage

// File: rtl/user_io_fifo.sv
// Byte FIFO with first-word fall-through read; push is accepted when full if a pop coincides.
module user_io_fifo #(
  parameter int unsigned AW = 6
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic [7:0] din_i,
  output logic [7:0] dout_o,
  output logic       empty_o,
  output logic       full_o
);

  logic [7:0]  mem_q [2**AW];
  logic [AW:0] wptr_q, rptr_q;
  logic        do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign dout_o  = mem_q[rptr_q[AW-1:0]];
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/user_io_spi_sync.sv
// SPI mode-0 slave oversampled on clk_sys: decodes joystick/status/button writes and
// streams the serial FIFO back to the host.
module user_io_spi_sync
  import user_io_pkg::*;
#(
  parameter int unsigned NUM_JOY   = 5,
  parameter int unsigned JOY_W     = 32,
  parameter int unsigned STATUS_W  = 64,
  parameter int unsigned FIFO_AW   = 6,
  parameter logic [7:0]  CORE_TYPE = 8'hA4
) (
  input  logic                     clk_sys,
  input  logic                     reset,
  input  logic                     SPI_CLK,
  input  logic                     SPI_SS_IO,
  input  logic                     SPI_MOSI,
  output logic                     SPI_MISO,
  output logic                     spi_miso_oe,
  output logic [NUM_JOY*JOY_W-1:0] joystick,
  output logic [STATUS_W-1:0]      status,
  output logic [1:0]               buttons,
  output logic [1:0]               switches,
  output logic                     scandoubler_disable,
  input  logic [7:0]               serial_data,
  input  logic                     serial_strobe,
  output logic                     serial_full,
  output logic                     serial_overflow
);

  localparam int unsigned JoyBytes  = JOY_W / 8;
  localparam int unsigned StatBytes = STATUS_W / 8;

  logic [2:0] sck_q, ss_q;
  logic [1:0] mosi_q;
  logic       sck_rise, sck_fall, sel, sel_edge, mosi_s, rx_done;

  logic [2:0]               bit_cnt_q, bit_cnt_d;
  logic [9:0]               byte_cnt_q, byte_cnt_d, nidx;
  logic [6:0]               rx_sr_q, rx_sr_d;
  logic [7:0]               cmd_q, cmd_d, tx_q, tx_d;
  logic                     miso_q, miso_d, oe_q, oe_d, active_q, active_d, ovf_q, ovf_d;
  logic [NUM_JOY*JOY_W-1:0] joy_q, joy_d;
  logic [STATUS_W-1:0]      status_q, status_d;
  // Only but_sw[4:0] is observable, so the upper three bits are not kept.
  logic [4:0]               but_sw_q, but_sw_d;
  logic [7:0]               rx_byte, cur_cmd, resp, fifo_dout;
  logic                     fifo_pop, fifo_empty, fifo_full;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sck_q  <= '0;
      ss_q   <= '0;
      mosi_q <= '0;
    end else begin
      sck_q  <= {sck_q[1:0], SPI_CLK};
      ss_q   <= {ss_q[1:0], SPI_SS_IO};
      mosi_q <= {mosi_q[0], SPI_MOSI};
    end
  end

  assign sck_rise = sck_q[1] & ~sck_q[2];
  assign sck_fall = ~sck_q[1] & sck_q[2];
  assign sel      = ~ss_q[1];
  assign sel_edge = ss_q[2] & ~ss_q[1];
  assign mosi_s   = mosi_q[1];
  assign rx_byte  = {rx_sr_q, mosi_s};
  assign rx_done  = sel & ~sel_edge & active_q & sck_rise & (bit_cnt_q == 3'd7);
  assign cur_cmd  = (byte_cnt_q == '0) ? rx_byte : cmd_q;
  assign nidx     = (byte_cnt_q == 10'd1023) ? byte_cnt_q : byte_cnt_q + 10'd1;

  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    rx_sr_d    = rx_sr_q;
    cmd_d      = cmd_q;
    tx_d       = tx_q;
    miso_d     = miso_q;
    oe_d       = oe_q;
    active_d   = active_q;
    ovf_d      = ovf_q;
    joy_d      = joy_q;
    status_d   = status_q;
    but_sw_d   = but_sw_q;
    fifo_pop   = 1'b0;
    resp       = 8'h00;

    if (!sel) begin
      bit_cnt_d  = '0;
      byte_cnt_d = '0;
      active_d   = 1'b0;
      oe_d       = 1'b0;
      miso_d     = 1'b0;
    end else if (sel_edge) begin
      bit_cnt_d  = '0;
      byte_cnt_d = '0;
      active_d   = 1'b1;
      oe_d       = 1'b1;
      tx_d       = CORE_TYPE;
      miso_d     = CORE_TYPE[7];
    end else if (active_q) begin
      if (sck_rise) begin
        rx_sr_d   = rx_byte[6:0];
        bit_cnt_d = bit_cnt_q + 3'd1;
      end else if (sck_fall) begin
        miso_d = tx_q[~bit_cnt_q];
      end
    end

    if (rx_done) begin
      byte_cnt_d = nidx;
      if (byte_cnt_q == '0) cmd_d = rx_byte;
      if (cur_cmd == CMD_BUT_SW && byte_cnt_q == 10'd1) but_sw_d = rx_byte[4:0];
      if (cur_cmd == CMD_STATUS8 && byte_cnt_q == 10'd1) status_d[7:0] = rx_byte;
      if (cur_cmd == CMD_SER_CLR && byte_cnt_q == '0) ovf_d = 1'b0;
      for (int unsigned k = 0; k < StatBytes; k++) begin
        if (cur_cmd == CMD_STATUS && byte_cnt_q == 10'(k + 1)) status_d[k*8 +: 8] = rx_byte;
      end
      for (int unsigned n = 0; n < NUM_JOY; n++) begin
        for (int unsigned k = 0; k < JoyBytes; k++) begin
          if (cur_cmd == CMD_JOY_BASE + 8'(n) && byte_cnt_q == 10'(k + 1)) begin
            joy_d[n*JOY_W + k*8 +: 8] = rx_byte;
          end
        end
      end
      // Odd slots report availability, even slots carry (and consume) the FIFO head.
      if (cur_cmd == CMD_SER_RD) begin
        if (nidx[0]) begin
          resp = ser_status(!fifo_empty);
        end else if (!fifo_empty) begin
          resp     = fifo_dout;
          fifo_pop = 1'b1;
        end
      end
      tx_d = resp;
    end

    if (serial_strobe && fifo_full && !fifo_pop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      rx_sr_q    <= '0;
      cmd_q      <= '0;
      tx_q       <= CORE_TYPE;
      miso_q     <= 1'b0;
      oe_q       <= 1'b0;
      active_q   <= 1'b0;
      ovf_q      <= 1'b0;
      joy_q      <= '0;
      status_q   <= '0;
      but_sw_q   <= '0;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      rx_sr_q    <= rx_sr_d;
      cmd_q      <= cmd_d;
      tx_q       <= tx_d;
      miso_q     <= miso_d;
      oe_q       <= oe_d;
      active_q   <= active_d;
      ovf_q      <= ovf_d;
      joy_q      <= joy_d;
      status_q   <= status_d;
      but_sw_q   <= but_sw_d;
    end
  end

  user_io_fifo #(
    .AW(FIFO_AW)
  ) u_fifo (
    .clk_i  (clk_sys),
    .rst_i  (reset),
    .push_i (serial_strobe),
    .pop_i  (fifo_pop),
    .din_i  (serial_data),
    .dout_o (fifo_dout),
    .empty_o(fifo_empty),
    .full_o (fifo_full)
  );

  assign SPI_MISO            = miso_q;
  assign spi_miso_oe         = oe_q;
  assign joystick            = joy_q;
  assign status              = status_q;
  assign buttons             = but_sw_q[1:0];
  assign switches            = but_sw_q[3:2];
  assign scandoubler_disable = but_sw_q[4];
  assign serial_full         = fifo_full;
  assign serial_overflow     = ovf_q;

endmodule

// File: tb/tb_user_io_spi_sync.sv
// Directed bench for user_io_spi_sync: table of SPI transfers plus FIFO, abort and reset sequences.
module tb_user_io_spi_sync;

  localparam int Half = 8;
  localparam int SelNone = 0, SelJoy0 = 1, SelJoy2 = 2, SelJoy4 = 3, SelJoy40 = 4;
  localparam int SelStat = 5, SelBut = 6, SelFlags = 7;

  logic         clk_sys = 1'b0;
  logic         reset;
  logic         SPI_CLK, SPI_SS_IO, SPI_MOSI, SPI_MISO, spi_miso_oe;
  logic [159:0] joystick;
  logic [63:0]  status;
  logic [1:0]   buttons, switches;
  logic         scandoubler_disable;
  logic [7:0]   serial_data;
  logic         serial_strobe, serial_full, serial_overflow;

  int n_chk = 0;
  int n_fail = 0;

  user_io_spi_sync dut (
    .clk_sys            (clk_sys),
    .reset              (reset),
    .SPI_CLK            (SPI_CLK),
    .SPI_SS_IO          (SPI_SS_IO),
    .SPI_MOSI           (SPI_MOSI),
    .SPI_MISO           (SPI_MISO),
    .spi_miso_oe        (spi_miso_oe),
    .joystick           (joystick),
    .status             (status),
    .buttons            (buttons),
    .switches           (switches),
    .scandoubler_disable(scandoubler_disable),
    .serial_data        (serial_data),
    .serial_strobe      (serial_strobe),
    .serial_full        (serial_full),
    .serial_overflow    (serial_overflow)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    int          len;
    logic [79:0] tx;   // byte 0 in [79:72]
    logic [79:0] rx;
    int          sel;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] observe(input int sel);
    case (sel)
      SelJoy0:  return {32'h0, joystick[31:0]};
      SelJoy2:  return {32'h0, joystick[95:64]};
      SelJoy4:  return {32'h0, joystick[159:128]};
      SelJoy40: return {joystick[159:128], joystick[31:0]};
      SelStat:  return status;
      SelBut:   return {59'h0, scandoubler_disable, switches, buttons};
      SelFlags: return {62'h0, serial_full, serial_overflow};
      default:  return 64'h0;
    endcase
  endfunction

  task automatic spi_byte(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i >= 8 - nbits; i--) begin
      SPI_MOSI = tx[i];
      repeat (Half) @(negedge clk_sys);
      rx[i] = SPI_MISO;
      SPI_CLK = 1'b1;
      repeat (Half) @(negedge clk_sys);
      SPI_CLK = 1'b0;
    end
  endtask

  task automatic spi_select();
    SPI_SS_IO = 1'b0;
    repeat (Half) @(negedge clk_sys);
  endtask

  task automatic spi_deselect(input string name);
    SPI_SS_IO = 1'b1;
    repeat (3) @(negedge clk_sys);
    check({name, " oe_fall"}, {63'h0, spi_miso_oe}, 64'h0);
    repeat (Half) @(negedge clk_sys);
  endtask

  task automatic push(input logic [7:0] d);
    serial_data   = d;
    serial_strobe = 1'b1;
    @(negedge clk_sys);
    serial_strobe = 1'b0;
  endtask

  logic [7:0] rb;

  initial begin
    vecs[0] = '{6, 80'h60_11_22_33_44_55_00_00_00_00, 80'hA4_00_00_00_00_00_00_00_00_00,
                SelJoy0, 64'h44332211};
    vecs[1] = '{9, 80'h1E_01_02_03_04_05_06_07_08_00, 80'hA4_00_00_00_00_00_00_00_00_00,
                SelStat, 64'h0807060504030201};
    vecs[2] = '{2, 80'h15_FF_00_00_00_00_00_00_00_00, 80'hA4_00_00_00_00_00_00_00_00_00,
                SelStat, 64'h08070605040302FF};
    vecs[3] = '{2, 80'h01_1D_00_00_00_00_00_00_00_00, 80'hA4_00_00_00_00_00_00_00_00_00,
                SelBut, 64'h1D};
    vecs[4] = '{5, 80'h64_AA_BB_CC_DD_00_00_00_00_00, 80'hA4_00_00_00_00_00_00_00_00_00,
                SelJoy4, 64'hDDCCBBAA};
    vecs[5] = '{3, 80'h65_01_02_00_00_00_00_00_00_00, 80'hA4_00_00_00_00_00_00_00_00_00,
                SelJoy40, 64'hDDCCBBAA_44332211};
    vecs[6] = '{2, 80'h42_33_00_00_00_00_00_00_00_00, 80'hA4_00_00_00_00_00_00_00_00_00,
                SelStat, 64'h08070605040302FF};
    vecs[7] = '{3, 80'h1B_00_00_00_00_00_00_00_00_00, 80'hA4_80_00_00_00_00_00_00_00_00,
                SelFlags, 64'h0};
    vecs[8] = '{7, 80'h62_01_02_03_04_05_06_00_00_00, 80'hA4_00_00_00_00_00_00_00_00_00,
                SelJoy2, 64'h04030201};

    reset = 1'b1; SPI_CLK = 1'b0; SPI_SS_IO = 1'b1; SPI_MOSI = 1'b0;
    serial_data = 8'h00; serial_strobe = 1'b0;
    repeat (4) @(negedge clk_sys);
    check("rst joystick", {63'h0, |joystick}, 64'h0);
    check("rst status", status, 64'h0);
    check("rst but_sw", observe(SelBut), 64'h0);
    check("rst miso/oe", {62'h0, SPI_MISO, spi_miso_oe}, 64'h0);
    check("rst flags", observe(SelFlags), 64'h0);
    reset = 1'b0;
    repeat (Half) @(negedge clk_sys);

    for (int v = 0; v < 9; v++) begin
      spi_select();
      for (int k = 0; k < vecs[v].len; k++) begin
        spi_byte(vecs[v].tx[79-8*k -: 8], 8, rb);
        check($sformatf("v%0d miso byte%0d", v, k), {56'h0, rb},
              {56'h0, vecs[v].rx[79-8*k -: 8]});
      end
      spi_deselect($sformatf("v%0d", v));
      check($sformatf("v%0d register", v), observe(vecs[v].sel), vecs[v].exp);
    end

    // Two-byte FIFO read-back
    push(8'h41);
    push(8'h42);
    begin
      logic [7:0] exp_rd [6];
      exp_rd = '{8'hA4, 8'h81, 8'h41, 8'h81, 8'h42, 8'h80};
      spi_select();
      spi_byte(8'h1B, 8, rb);
      check("fifo2 byte0", {56'h0, rb}, {56'h0, exp_rd[0]});
      for (int k = 1; k < 6; k++) begin
        spi_byte(8'h00, 8, rb);
        check($sformatf("fifo2 byte%0d", k), {56'h0, rb}, {56'h0, exp_rd[k]});
      end
      spi_deselect("fifo2");
    end
    spi_select();
    spi_byte(8'h1B, 8, rb);
    spi_byte(8'h00, 8, rb);
    check("fifo2 empty after", {56'h0, rb}, 64'h80);
    spi_deselect("fifo2b");

    // Fill to capacity and overflow by one
    for (int i = 0; i < 64; i++) push(8'(8'h10 + i));
    check("fill flags", observe(SelFlags), 64'h2);
    push(8'hEE);
    check("overflow flags", observe(SelFlags), 64'h3);
    spi_select();
    spi_byte(8'h1B, 8, rb);
    for (int k = 1; k <= 128; k++) begin
      spi_byte(8'h00, 8, rb);
      if (k % 2 == 1) check($sformatf("fill stat%0d", k), {56'h0, rb}, 64'h81);
      else check($sformatf("fill data%0d", k), {56'h0, rb}, 64'(8'h10 + k / 2 - 1));
    end
    spi_deselect("fill");
    check("drained flags", observe(SelFlags), 64'h1);
    spi_select();
    spi_byte(8'h1F, 8, rb);
    spi_deselect("clr");
    check("overflow cleared", observe(SelFlags), 64'h0);

    // Abort after five bits of a command
    spi_select();
    spi_byte(8'h01, 5, rb);
    spi_deselect("abort");
    check("abort but_sw kept", observe(SelBut), 64'h1D);
    spi_select();
    spi_byte(8'h01, 8, rb);
    spi_byte(8'h06, 8, rb);
    spi_deselect("after abort");
    check("after abort but_sw", observe(SelBut), 64'h06);

    // Reset in the middle of a joystick transfer
    spi_select();
    spi_byte(8'h61, 8, rb);
    spi_byte(8'h11, 8, rb);
    spi_byte(8'h22, 4, rb);
    reset = 1'b1;
    repeat (4) @(negedge clk_sys);
    reset = 1'b0;
    repeat (2) @(negedge clk_sys);
    check("midrst joystick", {63'h0, |joystick}, 64'h0);
    check("midrst status", status, 64'h0);
    check("midrst but_sw", observe(SelBut), 64'h0);
    check("midrst miso/oe", {62'h0, SPI_MISO, spi_miso_oe}, 64'h0);
    spi_byte(8'h22, 4, rb);
    spi_byte(8'h01, 8, rb);
    spi_byte(8'h1F, 8, rb);
    check("midrst ignored", observe(SelBut), 64'h0);
    check("midrst joy ignored", {63'h0, |joystick}, 64'h0);
    spi_deselect("midrst");
    spi_select();
    spi_byte(8'h01, 8, rb);
    spi_byte(8'h03, 8, rb);
    spi_deselect("reselect");
    check("reselect but_sw", observe(SelBut), 64'h03);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule
